// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the fetch PC, runs the imem request/ack handshake and
// feeds fetched words to the decoder through a small prefetch buffer.
// Build option IFETCH_PREFETCH_EN: two-entry circular buffer (DEPTH=2); when undefined,
// a single holding register (DEPTH=1). Handshake, flush and halt behave identically.
`timescale 1ns/1ps
module instruction_fetch_unit #(
    parameter int                       INSTRUCTION_WIDTH = 16,
    parameter int                       ADDRESS_WIDTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR      = '0,
    parameter int                       BIOS_SIZE         = 2048
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         branch_taken,
    input  logic [ADDRESS_WIDTH-1:0]     branch_target,
    input  logic                         halt,
    output logic                         imem_req,
    output logic [ADDRESS_WIDTH-1:0]     imem_addr,
    input  logic                         imem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [ADDRESS_WIDTH-1:0]     instr_pc,
    output logic                         is_bios,
    output logic                         halted
);

`ifdef IFETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [INSTRUCTION_WIDTH-1:0] IDLE_WORD  = {INSTRUCTION_WIDTH{1'b1}};
    localparam logic [ADDRESS_WIDTH:0]       BIOS_LIMIT = (ADDRESS_WIDTH + 1)'(BIOS_SIZE);

    logic [0:0]               state, state_n;
    logic [ADDRESS_WIDTH-1:0] fetch_pc, fetch_pc_n;
    logic                     drop, drop_n;
    logic [CNT_W-1:0]         count, count_n;
    logic                     rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;

    // Two slots are always declared; the single-register build never advances past slot 0.
    logic [INSTRUCTION_WIDTH-1:0] buf_data [2];
    logic [ADDRESS_WIDTH-1:0]     buf_pc   [2];
    logic                         buf_bios [2];

    logic                         ack_v, push, pop, flush, incoming_bios;
    logic                         req_n;
    logic [ADDRESS_WIDTH-1:0]     addr_n;
    logic                         head_valid_n, head_bios_n;
    logic [INSTRUCTION_WIDTH-1:0] head_data_n;
    logic [ADDRESS_WIDTH-1:0]     head_pc_n;

    function automatic logic ptr_inc(input logic p);
        return (DEPTH > 1) ? ~p : 1'b0;
    endfunction

    assign ack_v         = imem_req && imem_ack;
    assign incoming_bios = ({1'b0, imem_addr} < BIOS_LIMIT);
    assign halted        = (state == ST_HALTED);

    // Control decisions: branch beats halt beats normal push/pop; drop flag swallows stale acks.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        flush      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        state_n    = state;
        fetch_pc_n = fetch_pc;
        drop_n     = drop;
        if (branch_taken) begin
            flush      = 1'b1;
            state_n    = ST_RUN;
            fetch_pc_n = branch_target;
            drop_n     = imem_req && !imem_ack;
        end else if (halt && state == ST_RUN) begin
            flush   = 1'b1;
            state_n = ST_HALTED;
            drop_n  = imem_req && !imem_ack;
        end else begin
            pop = instr_valid && instr_ready;
            if (ack_v) begin
                if (drop) begin
                    drop_n = 1'b0;
                end else begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + ADDRESS_WIDTH'(1);
                end
            end
        end
    end

    // Buffer occupancy and circular pointers.
    always_comb begin
        count_n  = count;
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        if (flush) begin
            count_n  = '0;
            rd_ptr_n = 1'b0;
            wr_ptr_n = 1'b0;
        end else begin
            if (push) wr_ptr_n = ptr_inc(wr_ptr);
            if (pop)  rd_ptr_n = ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count_n = count + CNT_W'(1);
                2'b01:   count_n = count - CNT_W'(1);
                default: count_n = count;
            endcase
        end
    end

    // Next request (held until acked) and next head-of-buffer values for the output registers.
    always_comb begin
        req_n  = 1'b0;
        addr_n = imem_addr;
        if (imem_req && !imem_ack) begin
            req_n = 1'b1;
        end else if (state_n == ST_RUN && count_n < CNT_W'(DEPTH)) begin
            req_n  = 1'b1;
            addr_n = fetch_pc_n;
        end

        head_valid_n = (count_n != '0);
        head_data_n  = IDLE_WORD;
        head_pc_n    = '0;
        head_bios_n  = 1'b0;
        if (head_valid_n) begin
            // The new head is the word arriving this edge when it lands in the read slot.
            if (push && wr_ptr == rd_ptr_n) begin
                head_data_n = imem_data;
                head_pc_n   = imem_addr;
                head_bios_n = incoming_bios;
            end else begin
                head_data_n = buf_data[rd_ptr_n];
                head_pc_n   = buf_pc[rd_ptr_n];
                head_bios_n = buf_bios[rd_ptr_n];
            end
        end
    end

    // State, handshake and output registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_VECTOR;
            drop        <= 1'b0;
            count       <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instruction <= IDLE_WORD;
            instr_pc    <= '0;
            is_bios     <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            drop        <= drop_n;
            count       <= count_n;
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            instr_valid <= head_valid_n;
            instruction <= head_data_n;
            instr_pc    <= head_pc_n;
            is_bios     <= head_bios_n;
        end
    end

    // Buffer storage writes.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; occupancy alone decides which slots hold valid data.
        if (push) begin
            buf_data[wr_ptr] <= imem_data;
            buf_pc[wr_ptr]   <= imem_addr;
            buf_bios[wr_ptr] <= incoming_bios;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory model with programmable ack
// delay, scoreboard of expected decoder entries, branch-target vector table and
// hand-written sequences for drop, halt, wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

`ifdef IFETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
        logic        bios;
    } entry_t;

    typedef struct {
        logic [15:0] target;
        logic        exp_bios;
        logic [15:0] exp_data;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [15:0] instr_pc;
    logic        is_bios;
    logic        halted;

    instruction_fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .instr_pc      (instr_pc),
        .is_bios       (is_bios),
        .halted        (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    entry_t      sb[$];
    logic [15:0] exp_addr;
    logic        tb_drop, tb_halted;
    logic        prev_req, prev_ack;
    logic [15:0] prev_addr;
    int          mem_delay = 1;
    int          wait_cnt  = 0;
    vec_t        vecs[5];

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        sb.delete();
        exp_addr  = 16'h0000;
        tb_drop   = 1'b0;
        tb_halted = 1'b0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 16'h0000;
        wait_cnt  = 0;
        imem_ack  = 1'b0;
    endtask

    // One clock: check outputs, drive memory and the model, advance to posedge+1.
    task automatic cycle();
        logic   ack_now;
        logic   new_req;
        entry_t e;
        new_req = imem_req && (!prev_req || prev_ack);
        if (new_req) check("req_addr", 32'(imem_addr), 32'(exp_addr));
        if (prev_req && !prev_ack)
            check("req_hold", 32'({imem_req, imem_addr}), 32'({1'b1, prev_addr}));
        if (tb_halted) check("halted_no_new_req", 32'(new_req), 32'd0);
        check("halted_flag", 32'(halted), 32'(tb_halted));

        ack_now = 1'b0;
        if (imem_req) begin
            if (wait_cnt >= mem_delay) begin
                ack_now  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        imem_ack  = ack_now;
        imem_data = ack_now ? word_of(imem_addr) : 16'($urandom);

        if (instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got pc 0x%0h, expected no entry at %0t", instr_pc, $time);
            end else begin
                e = sb.pop_front();
                check("pop_pc",   32'(instr_pc),    32'(e.pc));
                check("pop_data", 32'(instruction), 32'(e.data));
                check("pop_bios", 32'(is_bios),     32'(e.bios));
            end
        end else if (!instr_valid) begin
            check("idle_outputs", {15'd0, instruction, is_bios}, {15'd0, 16'hFFFF, 1'b0});
            check("idle_pc", 32'(instr_pc), 32'd0);
        end

        if (branch_taken || (halt && !tb_halted)) begin
            sb.delete();
            if (ack_now)       tb_drop = 1'b0;
            else if (imem_req) tb_drop = 1'b1;
            if (branch_taken) begin
                tb_halted = 1'b0;
                exp_addr  = branch_target;
            end else begin
                tb_halted = 1'b1;
            end
        end else if (ack_now) begin
            if (tb_drop) begin
                tb_drop = 1'b0;
            end else begin
                sb.push_back('{pc: imem_addr, data: word_of(imem_addr), bios: (imem_addr < 16'd2048)});
                exp_addr = exp_addr + 16'd1;
            end
        end

        prev_req  = imem_req;
        prev_ack  = ack_now;
        prev_addr = imem_addr;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_branch(input logic [15:0] target);
        branch_target = target;
        branch_taken  = 1'b1;
        cycle();
        branch_taken  = 1'b0;
    endtask

    task automatic wait_head(input logic [15:0] pc, input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            if (instr_valid && instr_pc == pc) break;
            cycle();
        end
        check(name, 32'(instr_valid && instr_pc == pc), 32'd1);
    endtask

    task automatic wait_req(input logic [15:0] addr, input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            if (imem_req && imem_addr == addr && (!prev_req || prev_ack)) break;
            cycle();
        end
        check(name, 32'(imem_req && imem_addr == addr), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(imem_req),    32'd0);
        check({tag, "_addr"},  32'(imem_addr),   32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, 32'(instruction), 32'h0000_FFFF);
        check({tag, "_pc"},    32'(instr_pc),    32'd0);
        check({tag, "_bios"},  32'(is_bios),     32'd0);
        check({tag, "_halt"},  32'(halted),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{target: 16'h0000, exp_bios: 1'b1, exp_data: word_of(16'h0000)};
        vecs[1] = '{target: 16'h07FF, exp_bios: 1'b1, exp_data: word_of(16'h07FF)};
        vecs[2] = '{target: 16'h0800, exp_bios: 1'b0, exp_data: word_of(16'h0800)};
        vecs[3] = '{target: 16'h1234, exp_bios: 1'b0, exp_data: word_of(16'h1234)};
        vecs[4] = '{target: 16'hFFFF, exp_bios: 1'b0, exp_data: word_of(16'hFFFF)};

        reset = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        halt = 1'b0;
        imem_data = 16'h0000;
        instr_ready = 1'b0;
        reset_model();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");

        // Release reset; the request appears on the first edge.
        reset = 1'b1;
        instr_ready = 1'b1;
        mem_delay = 1;
        cycle();
        check("first_req", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0000}));

        // Streaming with one-cycle and zero-cycle memory.
        repeat (20) cycle();
        mem_delay = 0;
        repeat (12) cycle();

        // Decoder stall: buffer fills to DEPTH and requests stop.
        instr_ready = 1'b0;
        repeat (10) cycle();
        check("stall_occupancy", 32'(sb.size()), 32'(DEPTH));
        check("stall_req_low",   32'(imem_req),  32'd0);
        check("stall_valid",     32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        repeat (10) cycle();

        // Branch while a request to 0x0005 is pending with a 3-cycle ack.
        mem_delay = 3;
        pulse_branch(16'h0003);
        wait_req(16'h0005, 60, "reach_req_5");
        pulse_branch(16'h0900);
        check("branch_flush_valid", 32'(instr_valid), 32'd0);
        wait_head(16'h0900, 40, "branch_head_900");
        check("branch_bios_900", 32'(is_bios),     32'd0);
        check("branch_data_900", 32'(instruction), 32'(word_of(16'h0900)));
        repeat (4) cycle();

        // Halt, repeated halt, then branch out of HALTED.
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        check("halt_flag",  32'(halted),      32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        repeat (3) cycle();
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        repeat (6) cycle();
        check("halt_req_low",    32'(imem_req), 32'd0);
        check("halt_still_held", 32'(halted),   32'd1);
        pulse_branch(16'h0009);
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_req",  32'({imem_req, imem_addr}), 32'({1'b1, 16'h0009}));
        wait_head(16'h0009, 40, "unhalt_head_9");
        check("unhalt_data_9", 32'(instruction), 32'(word_of(16'h0009)));

        // Branch-target table: address, BIOS flag and data of the first entry.
        mem_delay = 1;
        for (int i = 0; i < 5; i++) begin
            pulse_branch(vecs[i].target);
            wait_head(vecs[i].target, 20, "vec_head");
            check("vec_bios", 32'(is_bios),     32'(vecs[i].exp_bios));
            check("vec_data", 32'(instruction), 32'(vecs[i].exp_data));
        end
        // The last vector started at 0xFFFF: the following fetch wraps to 0x0000.
        cycle();
        wait_head(16'h0000, 20, "wrap_head_0");
        check("wrap_bios", 32'(is_bios),     32'd1);
        check("wrap_data", 32'(instruction), 32'(word_of(16'h0000)));

        // Asynchronous reset while a request is outstanding.
        mem_delay = 3;
        cycle();
        for (int n = 0; n < 20; n++) begin
            if (imem_req && (!prev_req || prev_ack)) break;
            cycle();
        end
        check("pre_reset_req", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b0;
        imem_ack = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        reset_model();
        @(posedge clock);
        #1;
        reset = 1'b1;
        mem_delay = 1;
        cycle();
        check("restart_req", 32'({imem_req, imem_addr}), 32'({1'b1, 16'h0000}));
        repeat (10) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
